// File: rtl/nibble_add_sched_pkg.sv
// Shared definitions for the nibble-serial add scheduler.
//   - state_e        : scheduler FSM states
//   - NibblesDefault : default operand width in nibbles
//   - ReqId0/ReqId1  : requester identifiers reported on rsp_id
package nibble_add_sched_pkg;

    localparam int unsigned NibblesDefault = 4;

    localparam logic ReqId0 = 1'b0;
    localparam logic ReqId1 = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_add_sched_adder.sv
// Combinational 4-bit adder with carry-in; the only adder in the scheduler.
// Ports:
//   a, b : 4-bit addends
//   cin  : carry-in
//   sum  : 4-bit sum
//   cout : carry-out
module nibble_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign sum  = full[3:0];
    assign cout = full[4];

endmodule

// File: rtl/nibble_add_sched.sv
// Two-requester add scheduler. Requests are arbitrated round-robin and the
// granted operands are summed one nibble per cycle (LSB nibble first) through a
// single shared 4-bit adder. The result is held on the response port until the
// consumer accepts it.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   reqN_valid/ready            : request handshake for requester N (0, 1)
//   reqN_a, reqN_b, reqN_cin    : operands and carry-in for requester N
//   rsp_valid/ready             : response handshake
//   rsp_sum, rsp_cout, rsp_id   : result, carry-out, owning requester
// NIBBLES legal range is 2..8.
module nibble_add_sched
    import nibble_add_sched_pkg::*;
#(
    parameter int unsigned NIBBLES = NibblesDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_id
);

    localparam int unsigned W       = 4 * NIBBLES;
    localparam logic [2:0]  LastIdx = 3'(NIBBLES - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic [2:0]     idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           id_q, id_d;
    logic           last_grant_q, last_grant_d;

    logic           grant0, grant1;
    logic [3:0]     nib_a, nib_b, nib_sum;
    logic           nib_cout;

    // On a tie the requester that did not win last time gets the grant.
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    assign grant0 = req0_valid & ~grant1;

    assign nib_a = a_q[4*idx_q +: 4];
    assign nib_b = b_q[4*idx_q +: 4];

    nibble_adder u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        cout_d       = cout_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    a_d          = grant1 ? req1_a : req0_a;
                    b_d          = grant1 ? req1_b : req0_b;
                    carry_d      = grant1 ? req1_cin : req0_cin;
                    id_d         = grant1 ? ReqId1 : ReqId0;
                    idx_d        = 3'd0;
                    last_grant_d = grant1;
                    state_d      = StRun;
                end
            end
            StRun: begin
                sum_d[4*idx_q +: 4] = nib_sum;
                carry_d             = nib_cout;
                idx_d               = idx_q + 3'd1;
                if (idx_q == LastIdx) begin
                    cout_d  = nib_cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            idx_q        <= 3'd0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            id_q         <= ReqId0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            cout_q       <= cout_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs are forced low while rst is high, so stale state from an aborted
    // operation never reaches either port during the reset cycle itself.
    assign req0_ready = ~rst & (state_q == StIdle) & grant0;
    assign req1_ready = ~rst & (state_q == StIdle) & grant1;
    assign rsp_valid  = ~rst & (state_q == StDone);
    assign rsp_sum    = rst ? '0 : sum_q;
    assign rsp_cout   = ~rst & cout_q;
    assign rsp_id     = ~rst & id_q;

endmodule
